// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter between NUM_REQ byte-stream
// requesters. Round-robin grant, held for a whole packet (until a byte
// flagged last), with timeouts on the tx_busy handshake and on owner stalls.
module uart_tx_arbiter #(
  parameter int NUM_REQ       = 2,
  parameter int START_TIMEOUT = 16,
  parameter int HOLD_TIMEOUT  = 1000000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         i_req_valid,
  input  logic [8*NUM_REQ-1:0]       i_req_data,
  input  logic [NUM_REQ-1:0]         i_req_last,
  output logic [NUM_REQ-1:0]         o_req_ready,
  input  logic                       i_tx_busy,
  output logic                       o_tx_start,
  output logic [7:0]                 o_dout,
  output logic                       o_grant_valid,
  output logic [$clog2(NUM_REQ)-1:0] o_grant_id,
  output logic                       o_start_err,
  output logic                       o_hold_err
);

  localparam int IW  = $clog2(NUM_REQ);
  localparam int SCW = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;
  localparam int HCW = (HOLD_TIMEOUT > 1) ? $clog2(HOLD_TIMEOUT) : 1;

  localparam logic [SCW-1:0] START_LAST = SCW'(START_TIMEOUT - 1);
  localparam logic [HCW-1:0] HOLD_LAST  = HCW'(HOLD_TIMEOUT - 1);
  localparam logic [IW-1:0]  LAST_ID    = IW'(NUM_REQ - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    START,
    WAIT_HI,
    WAIT_LO
  } state_t;

  state_t          r_state,       w_state_nxt;
  logic [IW-1:0]   r_grant_id,    w_grant_id_nxt;
  logic            r_grant_valid, w_grant_valid_nxt;
  logic [IW-1:0]   r_last_grant,  w_last_grant_nxt;
  logic [7:0]      r_dout,        w_dout_nxt;
  logic            r_last_q,      w_last_q_nxt;
  logic [SCW-1:0]  r_start_cnt,   w_start_cnt_nxt;
  logic [HCW-1:0]  r_hold_cnt,    w_hold_cnt_nxt;
  logic            r_start_err,   w_start_err_nxt;
  logic            r_hold_err,    w_hold_err_nxt;

  logic            w_lane_valid;
  logic            w_lane_last;
  logic [7:0]      w_lane_byte;
  logic            w_pick_found;
  logic [IW-1:0]   w_pick_id;
  logic            w_accept;
  logic            w_byte_done;
  logic [NUM_REQ-1:0] w_ready;

  // Select the owner's lane (valid, last flag, byte) by grant id
  always_comb begin
    w_lane_valid = 1'b0;
    w_lane_last  = 1'b0;
    w_lane_byte  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_grant_id == IW'(i)) begin
        w_lane_valid = i_req_valid[i];
        w_lane_last  = i_req_last[i];
        w_lane_byte  = i_req_data[8*i +: 8];
      end
    end
  end

  // Round-robin pick: first requester after last_grant, wrapping; scanning
  // from the far end lets the nearest candidate overwrite the others
  always_comb begin
    int idx;
    idx          = 0;
    w_pick_found = 1'b0;
    w_pick_id    = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(r_last_grant) + k) % NUM_REQ;
      if (i_req_valid[idx]) begin
        w_pick_found = 1'b1;
        w_pick_id    = IW'(idx);
      end
    end
  end

  assign w_accept = (r_state == FETCH) && w_lane_valid && !i_tx_busy;

  // Only the owner's lane may see ready, and only while the transmitter is free
  always_comb begin
    w_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_ready[i] = w_accept && (r_grant_id == IW'(i));
    end
  end

  // Next-state and datapath updates; every register holds unless changed
  always_comb begin
    w_state_nxt       = r_state;
    w_grant_id_nxt    = r_grant_id;
    w_grant_valid_nxt = r_grant_valid;
    w_last_grant_nxt  = r_last_grant;
    w_dout_nxt        = r_dout;
    w_last_q_nxt      = r_last_q;
    w_start_cnt_nxt   = r_start_cnt;
    w_hold_cnt_nxt    = r_hold_cnt;
    w_start_err_nxt   = r_start_err;
    w_hold_err_nxt    = r_hold_err;
    w_byte_done       = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_pick_found) begin
          w_grant_id_nxt    = w_pick_id;
          w_grant_valid_nxt = 1'b1;
          w_hold_cnt_nxt    = '0;
          w_state_nxt       = FETCH;
        end
      end
      FETCH: begin
        if (w_accept) begin
          w_dout_nxt   = w_lane_byte;
          w_last_q_nxt = w_lane_last;
          w_state_nxt  = START;
        end else if (r_hold_cnt == HOLD_LAST) begin
          w_hold_err_nxt    = 1'b1;
          w_grant_valid_nxt = 1'b0;
          w_last_grant_nxt  = r_grant_id;
          w_state_nxt       = IDLE;
        end else begin
          w_hold_cnt_nxt = r_hold_cnt + HCW'(1);
        end
      end
      START: begin
        w_start_cnt_nxt = '0;
        w_state_nxt     = WAIT_HI;
      end
      WAIT_HI: begin
        if (i_tx_busy) begin
          w_state_nxt = WAIT_LO;
        end else if (r_start_cnt == START_LAST) begin
          w_start_err_nxt = 1'b1;
          w_byte_done     = 1'b1;
        end else begin
          w_start_cnt_nxt = r_start_cnt + SCW'(1);
        end
      end
      WAIT_LO: begin
        if (!i_tx_busy) begin
          w_byte_done = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    // A finished byte (sent or timed out) either ends the packet or fetches more
    if (w_byte_done) begin
      if (r_last_q) begin
        w_last_grant_nxt  = r_grant_id;
        w_grant_valid_nxt = 1'b0;
        w_state_nxt       = IDLE;
      end else begin
        w_hold_cnt_nxt = '0;
        w_state_nxt    = FETCH;
      end
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_grant_id    <= '0;
      r_grant_valid <= 1'b0;
      r_last_grant  <= LAST_ID;
      r_dout        <= '0;
      r_last_q      <= 1'b0;
      r_start_cnt   <= '0;
      r_hold_cnt    <= '0;
      r_start_err   <= 1'b0;
      r_hold_err    <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_grant_id    <= w_grant_id_nxt;
      r_grant_valid <= w_grant_valid_nxt;
      r_last_grant  <= w_last_grant_nxt;
      r_dout        <= w_dout_nxt;
      r_last_q      <= w_last_q_nxt;
      r_start_cnt   <= w_start_cnt_nxt;
      r_hold_cnt    <= w_hold_cnt_nxt;
      r_start_err   <= w_start_err_nxt;
      r_hold_err    <= w_hold_err_nxt;
    end
  end

  assign o_req_ready   = w_ready;
  assign o_tx_start    = (r_state == START);
  assign o_dout        = r_dout;
  assign o_grant_valid = r_grant_valid;
  assign o_grant_id    = r_grant_id;
  assign o_start_err   = r_start_err;
  assign o_hold_err    = r_hold_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: lane drivers, a transmitter model and a
// scoreboard monitor that checks every tx_start against queued expectations.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ       = 2;
  localparam int START_TIMEOUT = 16;
  localparam int HOLD_TIMEOUT  = 32;

  logic             clk;
  logic             rst;
  logic [1:0]       i_req_valid;
  logic [15:0]      i_req_data;
  logic [1:0]       i_req_last;
  logic [1:0]       o_req_ready;
  logic             i_tx_busy;
  logic             o_tx_start;
  logic [7:0]       o_dout;
  logic             o_grant_valid;
  logic [0:0]       o_grant_id;
  logic             o_start_err;
  logic             o_hold_err;

  typedef struct {
    logic [7:0] d;
    logic       last;
  } beat_t;

  typedef struct {
    logic [7:0] d;
    int         id;
  } exp_t;

  beat_t laneQ0[$];
  beat_t laneQ1[$];
  exp_t  sbQ[$];

  int   checks;
  int   errors;
  logic modelEnable;
  int   busyCnt;
  logic prevAccept;
  logic prevStart;

  uart_tx_arbiter #(
    .NUM_REQ(NUM_REQ),
    .START_TIMEOUT(START_TIMEOUT),
    .HOLD_TIMEOUT(HOLD_TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .i_req_valid(i_req_valid),
    .i_req_data(i_req_data),
    .i_req_last(i_req_last),
    .o_req_ready(o_req_ready),
    .i_tx_busy(i_tx_busy),
    .o_tx_start(o_tx_start),
    .o_dout(o_dout),
    .o_grant_valid(o_grant_valid),
    .o_grant_id(o_grant_id),
    .o_start_err(o_start_err),
    .o_hold_err(o_hold_err)
  );

  // Free-running clock, 10 time units per cycle
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Queue a byte on a lane and the transfer it should produce, in hand-computed order
  task automatic applyStimulus(input int lane, input logic [7:0] d, input logic last);
    beat_t b;
    exp_t  e;
    b.d    = d;
    b.last = last;
    e.d    = d;
    e.id   = lane;
    if (lane == 0) laneQ0.push_back(b);
    else           laneQ1.push_back(b);
    sbQ.push_back(e);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, " tx_start"},    32'(o_tx_start),    32'd0);
    checkOutput({tag, " dout"},        32'(o_dout),        32'd0);
    checkOutput({tag, " req_ready"},   32'(o_req_ready),   32'd0);
    checkOutput({tag, " grant_valid"}, 32'(o_grant_valid), 32'd0);
    checkOutput({tag, " grant_id"},    32'(o_grant_id),    32'd0);
    checkOutput({tag, " start_err"},   32'(o_start_err),   32'd0);
    checkOutput({tag, " hold_err"},    32'(o_hold_err),    32'd0);
  endtask

  task automatic resetDut();
    @(posedge clk);
    #1;
    rst = 1'b1;
    laneQ0.delete();
    laneQ1.delete();
    sbQ.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Wait until all stimulus is consumed and the DUT and transmitter are idle
  task automatic waitIdle(input int budget, input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(sbQ.size() == 0 && laneQ0.size() == 0 && laneQ1.size() == 0 &&
                 !o_grant_valid && !i_tx_busy) && n < budget);
    checkOutput({tag, " idle within budget"}, 32'(n < budget), 32'd1);
  endtask

  task automatic waitTxStart(input int budget, input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!o_tx_start && n < budget);
    checkOutput({tag, " tx_start seen"}, 32'(o_tx_start), 32'd1);
  endtask

  // Lane drivers: present each queue head, pop it once the DUT accepted it
  initial begin
    logic acc0, acc1;
    i_req_valid = '0;
    i_req_data  = '0;
    i_req_last  = '0;
    forever begin
      @(negedge clk);
      acc0 = o_req_ready[0] && i_req_valid[0];
      acc1 = o_req_ready[1] && i_req_valid[1];
      @(posedge clk);
      #1;
      if (rst) begin
        i_req_valid = '0;
        i_req_data  = '0;
        i_req_last  = '0;
      end else begin
        if (acc0 && laneQ0.size() != 0) void'(laneQ0.pop_front());
        if (acc1 && laneQ1.size() != 0) void'(laneQ1.pop_front());
        i_req_valid[0] = (laneQ0.size() != 0);
        i_req_data[7:0] = (laneQ0.size() != 0) ? laneQ0[0].d : 8'h00;
        i_req_last[0]  = (laneQ0.size() != 0) ? laneQ0[0].last : 1'b0;
        i_req_valid[1] = (laneQ1.size() != 0);
        i_req_data[15:8] = (laneQ1.size() != 0) ? laneQ1[0].d : 8'h00;
        i_req_last[1]  = (laneQ1.size() != 0) ? laneQ1[0].last : 1'b0;
      end
    end
  end

  // Transmitter model: busy rises the cycle after tx_start and lasts 20 cycles
  initial begin
    logic txs;
    i_tx_busy = 1'b0;
    busyCnt   = 0;
    forever begin
      @(negedge clk);
      txs = o_tx_start && modelEnable;
      @(posedge clk);
      #1;
      if (txs)              busyCnt = 20;
      else if (busyCnt > 0) busyCnt = busyCnt - 1;
      i_tx_busy = (busyCnt > 0);
    end
  end

  // Monitor: every tx_start must match the next expected byte and owner
  initial begin
    exp_t e;
    prevAccept = 1'b0;
    prevStart  = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prevAccept = 1'b0;
        prevStart  = 1'b0;
      end else begin
        if (o_tx_start) begin
          checkOutput("tx_start single cycle", 32'(prevStart), 32'd0);
          checkOutput("accept to tx_start latency", 32'(prevAccept), 32'd1);
          if (sbQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected tx_start: got dout 0x%0h, expected no transfer", o_dout);
          end else begin
            e = sbQ.pop_front();
            checkOutput("dout", 32'(o_dout), 32'(e.d));
            checkOutput("grant_id at start", 32'(o_grant_id), 32'(e.id));
            checkOutput("grant_valid at start", 32'(o_grant_valid), 32'd1);
          end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
          if (o_req_ready[i]) begin
            checkOutput($sformatf("req_ready[%0d] only for free owner", i),
                        32'(o_grant_valid && (int'(o_grant_id) == i) && i_req_valid[i] && !i_tx_busy),
                        32'd1);
          end
        end
        prevAccept = |(o_req_ready & i_req_valid);
        prevStart  = o_tx_start;
      end
    end
  end

  // Directed test sequence
  initial begin
    int n;
    checks      = 0;
    errors      = 0;
    modelEnable = 1'b1;
    rst         = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkResetValues("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // 1: single byte packet
    $display("[TB] test 1: single byte");
    applyStimulus(0, 8'h41, 1'b1);
    waitIdle(200, "t1");
    checkOutput("t1 grant_id after packet", 32'(o_grant_id), 32'd0);
    checkOutput("t1 grant_valid after packet", 32'(o_grant_valid), 32'd0);

    // 2: round robin, two rounds, requester 0 first both times
    $display("[TB] test 2: round robin");
    resetDut();
    applyStimulus(0, 8'h10, 1'b1);
    applyStimulus(1, 8'h20, 1'b1);
    waitIdle(300, "t2a");
    applyStimulus(0, 8'h10, 1'b1);
    applyStimulus(1, 8'h20, 1'b1);
    waitIdle(300, "t2b");
    checkOutput("t2 last owner", 32'(o_grant_id), 32'd1);

    // 3: packet lock, requester 1 arrives during requester 0's packet
    $display("[TB] test 3: packet lock");
    applyStimulus(0, 8'hA1, 1'b0);
    applyStimulus(0, 8'hA2, 1'b0);
    applyStimulus(0, 8'hA3, 1'b1);
    waitTxStart(100, "t3");
    applyStimulus(1, 8'hB1, 1'b1);
    waitIdle(500, "t3");

    // 4: start timeout with a silent transmitter
    $display("[TB] test 4: start timeout");
    checkOutput("t4 start_err before", 32'(o_start_err), 32'd0);
    modelEnable = 1'b0;
    applyStimulus(0, 8'h55, 1'b1);
    waitTxStart(100, "t4");
    n = 0;
    while (!o_start_err && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("t4 cycles tx_start to start_err", 32'(n), 32'd17);
    waitIdle(100, "t4a");
    checkOutput("t4 start_err sticky", 32'(o_start_err), 32'd1);
    checkOutput("t4 hold_err", 32'(o_hold_err), 32'd0);
    modelEnable = 1'b1;
    applyStimulus(1, 8'h66, 1'b1);
    waitIdle(200, "t4b");
    checkOutput("t4 start_err still set", 32'(o_start_err), 32'd1);

    // 5: hold timeout after owner stalls mid-packet
    $display("[TB] test 5: hold timeout");
    resetDut();
    applyStimulus(0, 8'h01, 1'b0);
    applyStimulus(1, 8'h02, 1'b1);
    waitTxStart(100, "t5");
    n = 0;
    while (!o_hold_err && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("t5 cycles tx_start to hold_err", 32'(n), 32'd54);
    checkOutput("t5 grant revoked", 32'(o_grant_valid), 32'd0);
    waitIdle(300, "t5");
    checkOutput("t5 hold_err sticky", 32'(o_hold_err), 32'd1);
    checkOutput("t5 start_err", 32'(o_start_err), 32'd0);

    // 6: reset during WAIT_HI of a multi-byte packet
    $display("[TB] test 6: reset mid-packet");
    resetDut();
    applyStimulus(0, 8'hC1, 1'b0);
    applyStimulus(0, 8'hC2, 1'b0);
    applyStimulus(0, 8'hC3, 1'b1);
    waitTxStart(100, "t6");
    @(posedge clk);
    #1;
    rst = 1'b1;
    laneQ0.delete();
    laneQ1.delete();
    sbQ.delete();
    @(negedge clk);
    @(negedge clk);
    checkResetValues("t6 mid-packet reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(0, 8'hC4, 1'b1);
    applyStimulus(1, 8'hD1, 1'b1);
    waitIdle(300, "t6");

    checkOutput("scoreboard drained", 32'(sbQ.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
